// File: rtl/nto1_mux_rr.sv
// N-channel, W-bit registered selector with valid/ready handshakes.
// Supports a fixed binary select or round-robin arbitration over valid channels.
module nto1_mux_rr #(
   parameter int N = 4,
   parameter int W = 1,
   localparam int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   grant,
   output logic           err
);

   localparam logic [SW:0]   NV   = (SW+1)'(N);
   localparam logic [SW-1:0] LAST = SW'(N-1);

   logic [W-1:0]  ch [N];
   logic [SW-1:0] ptr;
   logic [SW-1:0] c;
   logic [SW:0]   idx;
   logic [N-1:0]  c_oh;
   logic          chosen;
   logic          load_en;
   logic          xfer_in;

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign ch[k] = in_data[k*W +: W];
   end

   // Round-robin search starts at ptr; idx is one bit wider so the mod-N wrap
   // works for N that is not a power of two.
   always_comb begin
      chosen = 1'b0;
      c      = '0;
      idx    = '0;
      if (!mode) begin
         if ({1'b0, sel} < NV) begin
            chosen = 1'b1;
            c      = sel;
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (SW+1)'(i);
            if (idx >= NV) idx = idx - NV;
            if (!chosen && in_valid[idx[SW-1:0]]) begin
               chosen = 1'b1;
               c      = idx[SW-1:0];
            end
         end
      end
   end

   always_comb begin
      c_oh    = '0;
      c_oh[c] = 1'b1;
   end

   assign load_en  = !out_valid || out_ready;
   assign in_ready = (chosen && load_en && !reset) ? c_oh : '0;
   assign xfer_in  = chosen && load_en && in_valid[c] && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         grant     <= '0;
         err       <= 1'b0;
         ptr       <= '0;
      end else begin
         // In fixed mode "no channel chosen" can only mean sel is out of range.
         err <= !mode && !chosen && load_en;
         if (xfer_in) begin
            out_data  <= ch[c];
            out_valid <= 1'b1;
            grant     <= c_oh;
            if (mode) ptr <= (c == LAST) ? '0 : c + SW'(1);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nto1_mux_rr.sv
// Scoreboard bench for nto1_mux_rr: N=4/W=8 instance for main traffic,
// N=3/W=8 instance for out-of-range select handling.
module tb_nto1_mux_rr;

   logic        clk = 1'b0;
   logic        reset;

   logic [31:0] in_data_a;
   logic [3:0]  in_valid_a;
   logic [3:0]  in_ready_a;
   logic        mode_a;
   logic [1:0]  sel_a;
   logic [7:0]  out_data_a;
   logic        out_valid_a;
   logic        out_ready_a;
   logic [3:0]  grant_a;
   logic        err_a;

   logic [23:0] in_data_b;
   logic [2:0]  in_valid_b;
   logic [2:0]  in_ready_b;
   logic        mode_b;
   logic [1:0]  sel_b;
   logic [7:0]  out_data_b;
   logic        out_valid_b;
   logic        out_ready_b;
   logic [2:0]  grant_b;
   logic        err_b;

   int checks = 0;
   int errors = 0;
   logic [11:0] expq [$];

   always #5 clk = ~clk;

   nto1_mux_rr #(.N(4), .W(8)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .mode(mode_a), .sel(sel_a), .out_data(out_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .grant(grant_a), .err(err_a)
   );

   nto1_mux_rr #(.N(3), .W(8)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .mode(mode_b), .sel(sel_b), .out_data(out_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .grant(grant_b), .err(err_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Expected word for channel k is 8'h11*(k+1), grant one-hot(k).
   task automatic push(input int k);
      logic [7:0] d;
      logic [3:0] g;
      d = 8'h11 * (k + 1);
      g = 4'b0001 << k;
      expq.push_back({d, g});
   endtask

   // Monitor: every output transfer of dut_a consumes one expected entry.
   always @(negedge clk) begin
      if (!reset && out_valid_a && out_ready_a) begin
         if (expq.size() == 0) begin
            chk("unexpected_output", {20'h0, out_data_a, grant_a}, 32'h0);
         end else begin
            logic [11:0] e;
            e = expq.pop_front();
            chk("sb_data", {24'h0, out_data_a}, {24'h0, e[11:4]});
            chk("sb_grant", {28'h0, grant_a}, {28'h0, e[3:0]});
         end
      end
   end

   initial begin
      int rr_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int alt_seq [4] = '{1, 3, 1, 3};

      in_data_a   = 32'h44332211;
      in_data_b   = 24'hB3B2B1;
      in_valid_a  = 4'b1111;
      in_valid_b  = 3'b111;
      mode_a      = 1'b1;
      mode_b      = 1'b0;
      sel_a       = 2'd0;
      sel_b       = 2'd3;
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      reset       = 1'b1;

      // Reset with all channels valid
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("rst_in_ready_a", {28'h0, in_ready_a}, 32'h0);
         chk("rst_in_ready_b", {29'h0, in_ready_b}, 32'h0);
         cyc();
         chk("rst_out_valid", {31'h0, out_valid_a}, 32'h0);
         chk("rst_grant", {28'h0, grant_a}, 32'h0);
         chk("rst_err_b", {31'h0, err_b}, 32'h0);
      end
      in_valid_b = 3'b000;
      sel_b      = 2'd0;
      reset      = 1'b0;

      // Fixed mode, sel=2, full throughput
      mode_a = 1'b0;
      sel_a  = 2'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fix_in_ready", {28'h0, in_ready_a}, 32'h4);
         push(2);
         cyc();
         chk("fix_out_valid", {31'h0, out_valid_a}, 32'h1);
         chk("fix_err", {31'h0, err_a}, 32'h0);
      end

      // Round-robin, all valid
      mode_a = 1'b1;
      sel_a  = 2'd3;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("rr_in_ready", {28'h0, in_ready_a}, 32'h1 << rr_seq[i]);
         push(rr_seq[i]);
         cyc();
         chk("rr_err", {31'h0, err_a}, 32'h0);
      end

      // Round-robin, channels 1 and 3 only
      in_valid_a = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("alt_in_ready", {28'h0, in_ready_a}, 32'h1 << alt_seq[i]);
         push(alt_seq[i]);
         cyc();
      end

      // Backpressure: ptr=0, load channel 0 then stall 3 cycles
      in_valid_a = 4'b1111;
      #1;
      push(0);
      cyc();
      out_ready_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", {28'h0, in_ready_a}, 32'h0);
         cyc();
         chk("bp_out_data", {24'h0, out_data_a}, 32'h11);
         chk("bp_grant", {28'h0, grant_a}, 32'h1);
         chk("bp_out_valid", {31'h0, out_valid_a}, 32'h1);
      end
      out_ready_a = 1'b1;
      #1;
      chk("bp_release_in_ready", {28'h0, in_ready_a}, 32'h2);
      push(1);
      cyc();
      in_valid_a = 4'b0000;
      cyc();
      chk("drain_out_valid", {31'h0, out_valid_a}, 32'h0);

      // Reset while a word is held (ptr=2, word discarded)
      in_valid_a  = 4'b1111;
      out_ready_a = 1'b0;
      cyc();
      chk("held_data", {24'h0, out_data_a}, 32'h33);
      chk("held_valid", {31'h0, out_valid_a}, 32'h1);
      reset = 1'b1;
      #1;
      chk("midrst_in_ready", {28'h0, in_ready_a}, 32'h0);
      cyc();
      chk("midrst_out_valid", {31'h0, out_valid_a}, 32'h0);
      reset       = 1'b0;
      out_ready_a = 1'b1;
      #1;
      chk("postrst_in_ready", {28'h0, in_ready_a}, 32'h1);
      push(0);
      cyc();
      in_valid_a = 4'b0000;
      cyc();

      // N=3 bad select: err pulse, no load, then sel=1 loads channel 1
      in_valid_b = 3'b111;
      sel_b      = 2'd3;
      #1;
      chk("bad_in_ready", {29'h0, in_ready_b}, 32'h0);
      cyc();
      chk("bad_err", {31'h0, err_b}, 32'h1);
      chk("bad_out_valid", {31'h0, out_valid_b}, 32'h0);
      sel_b = 2'd1;
      #1;
      chk("good_in_ready", {29'h0, in_ready_b}, 32'h2);
      cyc();
      chk("good_err", {31'h0, err_b}, 32'h0);
      chk("good_out_valid", {31'h0, out_valid_b}, 32'h1);
      chk("good_out_data", {24'h0, out_data_b}, 32'hB2);
      chk("good_grant", {29'h0, grant_b}, 32'h2);
      // sel out of range while stalled: no load possible, so no err
      out_ready_b = 1'b0;
      sel_b       = 2'd3;
      cyc();
      chk("stall_bad_err", {31'h0, err_b}, 32'h0);
      chk("stall_out_data", {24'h0, out_data_b}, 32'hB2);

      chk("sb_empty", expq.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
